// File: rtl/mem_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_port_arbiter_pkg
//  Description : Shared definitions for the two-port memory arbiter:
//                default parameter values and the read-owner tag that
//                follows a read grant into the response cycle.
//  Revision    : 1.0  initial release
// ============================================================================
package mem_port_arbiter_pkg;

   localparam int unsigned DEF_ADDR_W     = 32;
   localparam int unsigned DEF_DATA_W     = 32;
   localparam int unsigned DEF_STARVE_MAX = 4;

   // Which requester owns the read data returning from memory next cycle.
   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_INST = 2'd1,
      OWN_DATA = 2'd2
   } owner_e;

endpackage : mem_port_arbiter_pkg
`default_nettype wire

// File: rtl/mem_arb_starve_cnt.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arb_starve_cnt
//  Description : Saturating count of consecutive cycles in which the data
//                port won while an instruction fetch was waiting. at_max
//                tells the arbiter to hand the next slot to the fetch.
//  Ports       : clk    - clock, rising edge
//                rst    - asynchronous reset, active low
//                inc    - data won while inst_req was pending
//                clr    - inst won or no fetch pending (dominates inc)
//                at_max - count has reached STARVE_MAX
//  Revision    : 1.0  initial release
// ============================================================================
module mem_arb_starve_cnt
   import mem_port_arbiter_pkg::*;
#(
   parameter int unsigned STARVE_MAX = DEF_STARVE_MAX
) (
   input  logic clk,
   input  logic rst,
   input  logic inc,
   input  logic clr,
   output logic at_max
);

   // $clog2(1) is 0, so keep at least one bit for STARVE_MAX = 0.
   localparam int unsigned            CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
   localparam logic [CNT_W-1:0]       C_MAX = CNT_W'(STARVE_MAX);
   localparam logic [CNT_W-1:0]       C_ONE = CNT_W'(1);

   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cnt <= '0;
      end else if (clr) begin
         r_cnt <= '0;
      end else if (inc && (r_cnt != C_MAX)) begin
         r_cnt <= r_cnt + C_ONE;
      end
   end

   assign at_max = (r_cnt == C_MAX);

endmodule : mem_arb_starve_cnt
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_port_arbiter
//  Description : Arbitrates an instruction-fetch port and a data port onto
//                one single-cycle-latency memory. Data has priority; a fetch
//                that has lost STARVE_MAX consecutive cycles wins the next.
//                Grants are combinational; read data returns one cycle later
//                on the port that owned the read.
//  Ports       : clk, rst                  clock, async active-low reset
//                inst_req/addr -> inst_gnt fetch request / accept
//                inst_rvalid, inst_rdata   fetch response
//                data_req/wen/addr/wdata   data request (wen = 0 is a read)
//                data_gnt                  data accept
//                data_rvalid, data_rdata   data read response
//                mem_en/wen/addr/wdata     shared memory request
//                mem_rdata                 memory read data (1-cycle latency)
//  Revision    : 1.0  initial release
// ============================================================================
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_W     = DEF_ADDR_W,
   parameter int unsigned DATA_W     = DEF_DATA_W,
   parameter int unsigned STARVE_MAX = DEF_STARVE_MAX
) (
   input  logic                clk,
   input  logic                rst,
   // instruction fetch port
   input  logic                inst_req,
   input  logic [ADDR_W-1:0]   inst_addr,
   output logic                inst_gnt,
   output logic                inst_rvalid,
   output logic [DATA_W-1:0]   inst_rdata,
   // data port
   input  logic                data_req,
   input  logic [DATA_W/8-1:0] data_wen,
   input  logic [ADDR_W-1:0]   data_addr,
   input  logic [DATA_W-1:0]   data_wdata,
   output logic                data_gnt,
   output logic                data_rvalid,
   output logic [DATA_W-1:0]   data_rdata,
   // shared memory port
   output logic                mem_en,
   output logic [DATA_W/8-1:0] mem_wen,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_wdata,
   input  logic [DATA_W-1:0]   mem_rdata
);

   localparam int unsigned BE_W = DATA_W / 8;

   logic      w_at_max;
   logic      w_inst_win;
   logic      w_data_win;
   logic      w_data_read;
   owner_e    r_owner;
   logic [DATA_W-1:0] r_inst_rdata;
   logic [DATA_W-1:0] r_data_rdata;

   // ------------------------------------------------------------------------
   // Arbitration. Qualifying with rst keeps every grant (and therefore every
   // memory access and owner update) off while reset is held.
   // ------------------------------------------------------------------------
   assign w_inst_win  = rst & inst_req & (~data_req | w_at_max);
   assign w_data_win  = rst & data_req & ~w_inst_win;
   assign w_data_read = (data_wen == {BE_W{1'b0}});

   assign inst_gnt = w_inst_win;
   assign data_gnt = w_data_win;

   // ------------------------------------------------------------------------
   // Memory request mux. Fields are not latched: requesters hold them until
   // granted, so the winner's live inputs go straight to memory.
   // ------------------------------------------------------------------------
   always_comb begin
      mem_en    = w_inst_win | w_data_win;
      mem_wen   = {BE_W{1'b0}};
      mem_addr  = {ADDR_W{1'b0}};
      mem_wdata = {DATA_W{1'b0}};
      if (w_inst_win) begin
         mem_addr = inst_addr;
      end else if (w_data_win) begin
         mem_wen   = data_wen;
         mem_addr  = data_addr;
         mem_wdata = data_wdata;
      end
   end

   // ------------------------------------------------------------------------
   // Starvation tracking: counts data wins that left a fetch waiting.
   // ------------------------------------------------------------------------
   mem_arb_starve_cnt #(
      .STARVE_MAX (STARVE_MAX)
   ) u_starve_cnt (
      .clk    (clk),
      .rst    (rst),
      .inc    (w_data_win & inst_req),
      .clr    (w_inst_win | ~inst_req),
      .at_max (w_at_max)
   );

   // ------------------------------------------------------------------------
   // Read owner tag: remembers who issued the read that memory answers next
   // cycle. Writes and idle cycles leave no owner, so no rvalid follows.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_owner <= OWN_NONE;
      end else if (w_inst_win) begin
         r_owner <= OWN_INST;
      end else if (w_data_win && w_data_read) begin
         r_owner <= OWN_DATA;
      end else begin
         r_owner <= OWN_NONE;
      end
   end

   assign inst_rvalid = (r_owner == OWN_INST);
   assign data_rvalid = (r_owner == OWN_DATA);

   // ------------------------------------------------------------------------
   // Read data. Memory data is only valid in the response cycle, so it is
   // passed through while rvalid is high and captured at the end of that
   // cycle so the port keeps showing it until its next response.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_inst_rdata <= {DATA_W{1'b0}};
         r_data_rdata <= {DATA_W{1'b0}};
      end else begin
         if (inst_rvalid) begin
            r_inst_rdata <= mem_rdata;
         end
         if (data_rvalid) begin
            r_data_rdata <= mem_rdata;
         end
      end
   end

   assign inst_rdata = inst_rvalid ? mem_rdata : r_inst_rdata;
   assign data_rdata = data_rvalid ? mem_rdata : r_data_rdata;

endmodule : mem_port_arbiter
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_port_arbiter
//  Description : Scoreboard bench for mem_port_arbiter. A driver issues
//                directed and random requests, predicts grants and read
//                responses from the arbitration rules and a word-array
//                memory image, and queues them; a negedge monitor pops the
//                queues and compares against the DUT. A behavioural memory
//                answers mem_* with one cycle of read latency.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mem_port_arbiter;

   localparam int SM     = 4;
   localparam int W_NONE = 0;
   localparam int W_I    = 1;
   localparam int W_D    = 2;

   typedef struct packed {
      logic        once;   // withdraw after one cycle without a grant
      logic [3:0]  wen;
      logic [31:0] addr;
      logic [31:0] wdata;
   } req_t;

   typedef struct packed {
      logic        ig;
      logic        dg;
      logic        en;
      logic [3:0]  wen;
      logic [31:0] addr;
      logic [31:0] wdata;
   } exp_g_t;

   typedef struct packed {
      int          cyc;
      logic        is_inst;
      logic [31:0] data;
   } rsp_t;

   logic        clk;
   logic        rst;
   logic        inst_req;
   logic [31:0] inst_addr;
   logic        inst_gnt;
   logic        inst_rvalid;
   logic [31:0] inst_rdata;
   logic        data_req;
   logic [3:0]  data_wen;
   logic [31:0] data_addr;
   logic [31:0] data_wdata;
   logic        data_gnt;
   logic        data_rvalid;
   logic [31:0] data_rdata;
   logic        mem_en;
   logic [3:0]  mem_wen;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   exp_g_t gq[$];
   rsp_t   rq[$];
   req_t   iq[$];
   req_t   dq[$];

   logic [31:0] mmem [0:255];   // reference image
   logic [31:0] dmem [0:255];   // memory device contents
   int          m_wait = 0;     // consecutive data wins with fetch waiting
   logic [31:0] last_i = '0;
   logic [31:0] last_d = '0;

   mem_port_arbiter #(
      .ADDR_W     (32),
      .DATA_W     (32),
      .STARVE_MAX (SM)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .inst_req    (inst_req),
      .inst_addr   (inst_addr),
      .inst_gnt    (inst_gnt),
      .inst_rvalid (inst_rvalid),
      .inst_rdata  (inst_rdata),
      .data_req    (data_req),
      .data_wen    (data_wen),
      .data_addr   (data_addr),
      .data_wdata  (data_wdata),
      .data_gnt    (data_gnt),
      .data_rvalid (data_rvalid),
      .data_rdata  (data_rdata),
      .mem_en      (mem_en),
      .mem_wen     (mem_wen),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .mem_rdata   (mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] mem_default(input logic [31:0] a);
      if (a == 32'h100) return 32'hDEADBEEF;
      return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                         input logic [3:0] be);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = wd[b*8 +: 8];
      return r;
   endfunction

   function automatic req_t rand_req(input bit is_data);
      req_t r;
      r.addr  = 32'($urandom_range(0, 15)) << 2;
      r.wen   = (is_data && $urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
      r.wdata = $urandom;
      r.once  = ($urandom_range(0, 9) == 0);
      return r;
   endfunction

   function automatic req_t mk(input logic [31:0] a, input logic [3:0] we,
                               input logic [31:0] wd, input logic once);
      req_t r;
      r.addr = a; r.wen = we; r.wdata = wd; r.once = once;
      return r;
   endfunction

   initial begin
      for (int i = 0; i < 256; i++) begin
         mmem[i] = mem_default(32'(i) << 2);
         dmem[i] = mem_default(32'(i) << 2);
      end
   end

   // Memory device: read data valid one cycle after an enabled read,
   // random garbage otherwise.
   always @(posedge clk) begin
      if (mem_en && mem_wen == 4'h0) mem_rdata <= dmem[mem_addr[9:2]];
      else                           mem_rdata <= $urandom;
      if (mem_en && mem_wen != 4'h0)
         dmem[mem_addr[9:2]] <= merge(dmem[mem_addr[9:2]], mem_wdata, mem_wen);
   end

   // ------------------------------------------------------------------------
   // Driver + reference model: one call drives one cycle.
   // ------------------------------------------------------------------------
   task automatic step(input logic iv, input req_t ir, input logic dv, input req_t dr,
                       output int win);
      exp_g_t e;
      rsp_t   r;
      @(posedge clk); #1;
      inst_req   = iv;
      inst_addr  = ir.addr;
      data_req   = dv;
      data_wen   = dr.wen;
      data_addr  = dr.addr;
      data_wdata = dr.wdata;
      win = W_NONE;
      if (rst) begin
         if (iv && dv) win = (m_wait == SM) ? W_I : W_D;
         else if (iv)  win = W_I;
         else if (dv)  win = W_D;
         if (win == W_D && iv) m_wait = (m_wait < SM) ? m_wait + 1 : m_wait;
         else                  m_wait = 0;
      end
      e = '0;
      e.ig = (win == W_I);
      e.dg = (win == W_D);
      e.en = (win != W_NONE);
      if (win == W_I) begin
         e.addr = ir.addr;
         r.cyc = cyc + 1; r.is_inst = 1'b1; r.data = mmem[ir.addr[9:2]];
         rq.push_back(r);
      end else if (win == W_D) begin
         e.addr = dr.addr; e.wen = dr.wen; e.wdata = dr.wdata;
         if (dr.wen == 4'h0) begin
            r.cyc = cyc + 1; r.is_inst = 1'b0; r.data = mmem[dr.addr[9:2]];
            rq.push_back(r);
         end else begin
            mmem[dr.addr[9:2]] = merge(mmem[dr.addr[9:2]], dr.wdata, dr.wen);
         end
      end
      gq.push_back(e);
   endtask

   task automatic hold_reset(input int n);
      int w;
      rst = 1'b0;
      rq.delete();
      m_wait = 0;
      last_i = '0;
      last_d = '0;
      for (int i = 0; i < n; i++) step(1'b1, rand_req(1'b0), 1'b1, rand_req(1'b1), w);
      @(posedge clk); #1;
      rst = 1'b1;
      inst_req = 1'b0;
      data_req = 1'b0;
   endtask

   // Requesters hold the head of their queue until granted (or withdraw it).
   task automatic run_agent(input int budget, input bit gaps);
      int   n;
      int   w;
      logic iv, dv;
      req_t ih, dh;
      n = 0;
      while ((iq.size() > 0 || dq.size() > 0) && n < budget) begin
         iv = (iq.size() > 0);
         dv = (dq.size() > 0);
         if (gaps && iv && $urandom_range(0, 7) == 0) iv = 1'b0;
         if (gaps && dv && $urandom_range(0, 7) == 0) dv = 1'b0;
         ih = (iq.size() > 0) ? iq[0] : '0;
         dh = (dq.size() > 0) ? dq[0] : '0;
         step(iv, ih, dv, dh, w);
         if (w == W_I || (iv && ih.once)) void'(iq.pop_front());
         if (w == W_D || (dv && dh.once)) void'(dq.pop_front());
         n++;
      end
      n_tests++;
      if (iq.size() > 0 || dq.size() > 0) begin
         n_fail++;
         $display("FAIL agent_drain: %0d inst / %0d data requests still pending, want 0",
                  iq.size(), dq.size());
         iq.delete();
         dq.delete();
      end
   endtask

   // ------------------------------------------------------------------------
   // Monitor
   // ------------------------------------------------------------------------
   initial begin : monitor
      exp_g_t      e;
      rsp_t        r;
      logic        due_i, due_d;
      logic [31:0] xi, xd;
      forever begin
         @(negedge clk);
         if (gq.size() > 0) begin
            e = gq.pop_front();
            n_tests++;
            if (inst_gnt !== e.ig || data_gnt !== e.dg || mem_en !== e.en || mem_wen !== e.wen ||
                (e.en && mem_addr !== e.addr) || (e.dg && mem_wdata !== e.wdata)) begin
               n_fail++;
               $display("FAIL grant cyc=%0d: got ig=%b dg=%b en=%b wen=%h addr=%h wdata=%h, want ig=%b dg=%b en=%b wen=%h addr=%h wdata=%h",
                        cyc, inst_gnt, data_gnt, mem_en, mem_wen, mem_addr, mem_wdata,
                        e.ig, e.dg, e.en, e.wen, e.addr, e.wdata);
            end
         end
         while (rq.size() > 0 && rq[0].cyc < cyc) begin
            r = rq.pop_front();
            n_tests++;
            n_fail++;
            $display("FAIL stale_rsp cyc=%0d: response due cyc %0d never matched", cyc, r.cyc);
         end
         due_i = 1'b0;
         due_d = 1'b0;
         xi = last_i;
         xd = last_d;
         if (rq.size() > 0 && rq[0].cyc == cyc) begin
            r = rq.pop_front();
            due_i = r.is_inst;
            due_d = !r.is_inst;
            if (due_i) xi = r.data; else xd = r.data;
         end
         n_tests++;
         if (inst_rvalid !== due_i || data_rvalid !== due_d) begin
            n_fail++;
            $display("FAIL rvalid cyc=%0d: got i=%b d=%b, want i=%b d=%b",
                     cyc, inst_rvalid, data_rvalid, due_i, due_d);
         end
         n_tests++;
         if (inst_rdata !== xi) begin
            n_fail++;
            $display("FAIL inst_rdata cyc=%0d: got %h, want %h", cyc, inst_rdata, xi);
         end
         n_tests++;
         if (data_rdata !== xd) begin
            n_fail++;
            $display("FAIL data_rdata cyc=%0d: got %h, want %h", cyc, data_rdata, xd);
         end
         last_i = xi;
         last_d = xd;
      end
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   // ------------------------------------------------------------------------
   // Stimulus
   // ------------------------------------------------------------------------
   initial begin : stim
      int   w;
      req_t z;
      z = '0;
      inst_req = 1'b0; inst_addr = '0;
      data_req = 1'b0; data_wen = '0; data_addr = '0; data_wdata = '0;
      hold_reset(3);

      // Lone fetch of 0x100.
      step(1'b1, mk(32'h100, 4'h0, 32'h0, 1'b0), 1'b0, z, w);
      step(1'b0, z, 1'b0, z, w);

      // Fetch and data write together: write first, then fetch of same word.
      iq.push_back(mk(32'h200, 4'h0, 32'h0, 1'b0));
      dq.push_back(mk(32'h200, 4'hF, 32'h12345678, 1'b0));
      run_agent(10, 1'b0);
      step(1'b0, z, 1'b0, z, w);

      // Starvation: six data reads against a held fetch.
      for (int i = 0; i < 6; i++) dq.push_back(mk(32'h10 + 32'(i * 4), 4'h0, 32'h0, 1'b0));
      iq.push_back(mk(32'h80, 4'h0, 32'h0, 1'b0));
      run_agent(20, 1'b0);
      step(1'b0, z, 1'b0, z, w);

      // Alternating single-port reads, back to back.
      for (int i = 0; i < 8; i++) begin
         step(1'b1, mk(32'(i * 8), 4'h0, 32'h0, 1'b0), 1'b0, z, w);
         step(1'b0, z, 1'b1, mk(32'(i * 8 + 4), 4'h0, 32'h0, 1'b0), w);
      end
      step(1'b0, z, 1'b0, z, w);

      // Data read granted, reset asserted before the response edge.
      step(1'b0, z, 1'b1, mk(32'h44, 4'h0, 32'h0, 1'b0), w);
      #6;
      hold_reset(2);
      step(1'b0, z, 1'b0, z, w);

      // Fetch raised for one losing cycle then withdrawn; the counter must
      // restart, so the next held fetch waits a full STARVE_MAX data wins.
      dq.push_back(mk(32'h20, 4'h0, 32'h0, 1'b0));
      dq.push_back(mk(32'h24, 4'h0, 32'h0, 1'b0));
      iq.push_back(mk(32'h28, 4'h0, 32'h0, 1'b1));
      run_agent(10, 1'b0);
      for (int i = 0; i < 5; i++) dq.push_back(mk(32'h30 + 32'(i * 4), 4'h0, 32'h0, 1'b0));
      iq.push_back(mk(32'h2C, 4'h0, 32'h0, 1'b0));
      run_agent(20, 1'b0);

      // Random traffic with gaps and withdrawals.
      for (int blk = 0; blk < 12; blk++) begin
         for (int i = 0; i < $urandom_range(1, 8); i++) iq.push_back(rand_req(1'b0));
         for (int i = 0; i < $urandom_range(1, 12); i++) dq.push_back(rand_req(1'b1));
         run_agent(200, 1'b1);
      end

      repeat (3) step(1'b0, z, 1'b0, z, w);
      @(negedge clk); #1;
      n_tests++;
      if (gq.size() != 0 || rq.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: %0d grants / %0d responses unmatched, want 0",
                  gq.size(), rq.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_mem_port_arbiter
`default_nettype wire

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 32, meaning the address width.
REQ-002 The block SHALL have parameter DATA_W, default 32, meaning the data width (multiple of 8).
REQ-003 The block SHALL have parameter STARVE_MAX, default 4, meaning the number of consecutive data wins after which a waiting inst request is forced through.
REQ-004 The block SHALL have one clock and one reset, listed first:
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
REQ-005 The block SHALL have the following inst requester ports:
- inst_req  in  1  fetch request.
- inst_addr  in  ADDR_W  fetch address.
- inst_gnt  out  1  request accepted this cycle.
- inst_rvalid  out  1  read data valid.
- inst_rdata  out  DATA_W  read data.
REQ-006 The block SHALL have the following data requester ports:
- data_req  in  1  access request.
- data_wen  in  DATA_W/8  byte write enables; zero means read.
- data_addr  in  ADDR_W  access address.
- data_wdata  in  DATA_W  write data.
- data_gnt  out  1  request accepted this cycle.
- data_rvalid  out  1  read data valid.
- data_rdata  out  DATA_W  read data.
REQ-007 The block SHALL have the following shared memory ports:
- mem_en  out  1  access enable.
- mem_wen  out  DATA_W/8  byte enables.
- mem_addr  out  ADDR_W  address.
- mem_wdata  out  DATA_W  write data.
- mem_rdata  in  DATA_W  read data, valid exactly one cycle after an mem_en read.

Function
REQ-008 Arbitration SHALL be combinational within the cycle: at most one of inst_gnt/data_gnt is high, and a grant requires the matching req.
- Only one requester active: that requester wins.
- Both active: data wins, unless the starvation count equals STARVE_MAX, in which case inst wins.
REQ-009 A granted request SHALL drive mem_en=1 and the winner's addr/wen/wdata onto mem_* in the same cycle.
- inst accesses always drive mem_wen=0.
- With no grant, mem_en=0 and mem_wen=0.
REQ-010 Requesters SHALL hold req and all request fields stable until gnt; the block SHALL not latch request fields.
REQ-011 The starvation counter (width clog2(STARVE_MAX+1)) SHALL behave as follows:
- Increment, saturating at STARVE_MAX, in each cycle where data wins while inst_req=1.
- Clear in any cycle where inst wins or inst_req=0.
REQ-012 A read grant SHALL register an owner tag (NONE/INST/DATA). In the next cycle:
- The owner's rvalid pulses high for exactly one cycle.
- The owner's rdata loads mem_rdata.
REQ-013 Write grants SHALL set the owner tag to NONE and produce no rvalid.
REQ-014 inst_rdata/data_rdata SHALL hold their last loaded value until the next read response for that port.
REQ-015 Back-to-back reads SHALL sustain one grant per cycle: the grant in cycle N+1 and the response for cycle N coexist with no bubble.
REQ-016 A request whose req drops before gnt SHALL be silently withdrawn with no side effect.

Reset
REQ-017 While rst=0 the block SHALL hold every register cleared:
- owner tag NONE.
- starvation counter 0.
- inst_rvalid/data_rvalid 0.
- inst_rdata/data_rdata 0.
REQ-018 A read granted in the cycle reset asserts SHALL produce no rvalid after reset releases.
REQ-019 While rst=0, gnt outputs and mem_en SHALL be 0.

Structure
REQ-020 A shared package SHALL hold the owner-tag enum (OWN_NONE, OWN_INST, OWN_DATA) and the default parameter constants.
REQ-021 The starvation counter SHALL be a sub-module, mem_arb_starve_cnt, with inputs inc, clr and output at_max.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- Lone inst read of addr 0x100, with mem returning 0xDEADBEEF -> inst_gnt same cycle; next cycle inst_rvalid=1 and inst_rdata=0xDEADBEEF; data_rvalid stays 0.
- Simultaneous inst read and data write (wen=0xF, addr 0x200, wdata 0x12345678) -> data_gnt first with mem_wen=0xF and mem_wdata=0x12345678; next cycle inst_gnt; no data_rvalid.
- data_req held high with 6 reads, inst_req held high, STARVE_MAX=4 -> grant sequence D,D,D,D,I,D,D; counter clears after I.
- Alternating inst/data reads every cycle -> one mem_en per cycle; each rvalid lands on the correct port with the correct rdata; no bubble.
- Data read granted, then rst=0 on the following edge -> no data_rvalid; data_rdata=0 after release.
- inst_req raised for one cycle while data wins, then dropped -> no inst_gnt and no inst_rvalid; counter returns to 0.
